// File: rtl/color_box_vga_renderer.sv
// Four-box colour renderer: VGA raster timing, per-frame shadow of fullColor, registered RGB/sync.
// Optional build macro BOX_BORDER_EN draws a 2 px white border just inside every box.
`timescale 1ns/1ps
module color_box_vga_renderer #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned BOX_X0   = 44,
  parameter int unsigned BOX_W    = 120,
  parameter int unsigned BOX_GAP  = 24,
  parameter int unsigned BOX_Y    = 180,
  parameter int unsigned BOX_H    = 120,
  parameter logic [11:0] BG_COLOR = 12'h000,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [47:0] fullColor,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FRONT + V_SYNC);
  localparam logic [9:0] BOX_TOP = 10'(BOX_Y);
  localparam logic [9:0] BOX_BOT = 10'(BOX_Y + BOX_H);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic [47:0]      shadow_q, shadow_d;
  logic [11:0]      rgb_q, rgb_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             fs_q, fs_d;

  logic             pix_tick;
  logic             h_wrap;
  logic             v_wrap;
  logic             active;
  logic             y_in;
  logic [3:0]       box_hit;

  // Raster counters and the frame shadow; all state moves only on the pixel tick
  always_comb begin
    pix_tick = (div_q == DIV_LAST);
    h_wrap   = (h_q == H_LAST);
    v_wrap   = (v_q == V_LAST);
    div_d    = pix_tick ? '0 : div_q + DIV_W'(1);
    h_d      = h_q;
    v_d      = v_q;
    shadow_d = shadow_q;
    fs_d     = 1'b0;
    if (pix_tick) begin
      h_d = h_wrap ? '0 : h_q + 10'd1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 10'd1;
      end
      if (h_wrap && v_wrap) begin
        shadow_d = fullColor;
        fs_d     = 1'b1;
      end
    end
  end

  assign active = (h_q < H_ACT) && (v_q < V_ACT);
  assign y_in   = (v_q >= BOX_TOP) && (v_q < BOX_BOT);

`ifdef BOX_BORDER_EN
  localparam logic [9:0] BRD_TOP = BOX_TOP + 10'd2;
  localparam logic [9:0] BRD_BOT = BOX_BOT - 10'd2;
  logic [3:0] box_edge;
  logic       y_edge;
  assign y_edge = (v_q < BRD_TOP) || (v_q >= BRD_BOT);
`endif

  for (genvar g = 0; g < 4; g++) begin : g_box
    localparam logic [9:0] LEFT  = 10'(BOX_X0 + g * (BOX_W + BOX_GAP));
    localparam logic [9:0] RIGHT = 10'(BOX_X0 + g * (BOX_W + BOX_GAP) + BOX_W);
    assign box_hit[g] = y_in && (h_q >= LEFT) && (h_q < RIGHT);
`ifdef BOX_BORDER_EN
    assign box_edge[g] = y_edge || (h_q < LEFT + 10'd2) || (h_q >= RIGHT - 10'd2);
`endif
  end

  // Boxes are disjoint, so the loop order never decides between two hits
  always_comb begin
    rgb_d = 12'h000;
    if (active) begin
      rgb_d = BG_COLOR;
      for (int unsigned i = 0; i < 4; i++) begin
        if (box_hit[i]) begin
`ifdef BOX_BORDER_EN
          rgb_d = box_edge[i] ? 12'hFFF : shadow_q[12*i +: 12];
`else
          rgb_d = shadow_q[12*i +: 12];
`endif
        end
      end
    end
    hsync_d = !((h_q >= HS_BEG) && (h_q < HS_END));
    vsync_d = !((v_q >= VS_BEG) && (v_q < VS_END));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      shadow_q <= '0;
      rgb_q    <= '0;
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      shadow_q <= shadow_d;
      rgb_q    <= rgb_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      fs_q     <= fs_d;
    end
  end

  assign rgb         = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_color_box_vga_renderer.sv
// Bench: a default-timing instance for sync/tick timing plus a shrunken-raster instance for frame behaviour.
`timescale 1ns/1ps
module tb_color_box_vga_renderer;

  localparam int unsigned D   = 2;
  localparam int unsigned HA  = 64, HF = 4, HS = 8, HB = 4;
  localparam int unsigned VA  = 40, VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT  = HA + HF + HS + HB;
  localparam int unsigned VT  = VA + VF + VS + VB;
  localparam int unsigned FC  = D * HT * VT;
  localparam int unsigned BX0 = 4, BW = 10, BGAP = 4, BY = 10, BH = 12;
  localparam logic [11:0] BGC = 12'h123;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [47:0] fullColor = '0;
  logic [11:0] rgb, rgb0;
  logic        hsync, vsync, fs, hsync0, vsync0, fs0;

  int unsigned cyc = 0;
  logic [47:0] shadow_m [16];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  color_box_vga_renderer #(
    .CLK_DIV(D), .BOX_X0(BX0), .BOX_W(BW), .BOX_GAP(BGAP), .BOX_Y(BY), .BOX_H(BH),
    .BG_COLOR(BGC), .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .reset(reset), .fullColor(fullColor),
    .rgb(rgb), .hsync(hsync), .vsync(vsync), .frame_start(fs)
  );

  color_box_vga_renderer dut0 (
    .clk(clk), .reset(reset), .fullColor(fullColor),
    .rgb(rgb0), .hsync(hsync0), .vsync(vsync0), .frame_start(fs0)
  );

  // Reference timeline: cyc counts clocks since reset release; frame f shows the word present at frame f's start
  always @(posedge clk) begin
    if (reset) begin
      cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if ((cyc + 1) % FC == 0 && (cyc + 1) / FC < 16) shadow_m[(cyc + 1) / FC] <= fullColor;
    end
  end

  function automatic logic [11:0] exp_rgb(int unsigned x, int unsigned y, logic [47:0] sh);
    if (x >= HA || y >= VA) return 12'h000;
    for (int i = 0; i < 4; i++) begin
      int unsigned l;
      l = BX0 + i * (BW + BGAP);
      if (x >= l && x < l + BW && y >= BY && y < BY + BH) begin
`ifdef BOX_BORDER_EN
        if (x < l + 2 || x >= l + BW - 2 || y < BY + 2 || y >= BY + BH - 2) return 12'hFFF;
`endif
        return sh[12*i +: 12];
      end
    end
    return BGC;
  endfunction

  function automatic logic exp_hs(int unsigned x);
    return !(x >= HA + HF && x < HA + HF + HS);
  endfunction

  function automatic logic exp_vs(int unsigned y);
    return !(y >= VA + VF && y < VA + VF + VS);
  endfunction

  task automatic wait_cyc(int unsigned n);
    int unsigned guard = 0;
    if (cyc > n) begin
      errors++;
      $display("FAIL schedule: cycle %0d already passed, now at %0d", n, cyc);
    end
    while (cyc < n && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < n) begin
      errors++;
      $display("FAIL wait_timeout: reached cycle %0d, required %0d", cyc, n);
    end
  endtask

  task automatic wait_px(int unsigned fr, int unsigned x, int unsigned y);
    wait_cyc(fr * FC + 1 + D * (y * HT + x));
  endtask

  task automatic test_reset();
    fullColor = 48'h08C_FF0_F0F_0FF;
    reset = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h expected 000", rgb); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", vsync); end
    checks++; if (fs !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", fs); end
    checks++; if (rgb0 !== 12'h000) begin errors++; $display("FAIL reset_rgb0: got %h expected 000", rgb0); end
    checks++; if (hsync0 !== 1'b1 || vsync0 !== 1'b1) begin errors++; $display("FAIL reset_sync0: got %b%b expected 11", hsync0, vsync0); end
    reset = 1'b0;
  endtask

  task automatic test_first_frame_shadow();
    wait_px(0, 2, 15);
    checks++; if (rgb !== BGC) begin errors++; $display("FAIL f0_background: got %h expected %h", rgb, BGC); end
    wait_px(0, 8, 15);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL f0_shadow_zero: got %h expected 000", rgb); end
  endtask

  task automatic test_hsync_timing();
    wait_cyc(2624);
    checks++; if (hsync0 !== 1'b1) begin errors++; $display("FAIL hsync_before: got %b expected 1", hsync0); end
    wait_cyc(2625);
    checks++; if (hsync0 !== 1'b0) begin errors++; $display("FAIL hsync_fall: got %b expected 0", hsync0); end
    checks++; if (vsync0 !== 1'b1) begin errors++; $display("FAIL vsync0_line0: got %b expected 1", vsync0); end
    wait_cyc(3008);
    checks++; if (hsync0 !== 1'b0) begin errors++; $display("FAIL hsync_last_low: got %b expected 0", hsync0); end
    wait_cyc(3009);
    checks++; if (hsync0 !== 1'b1) begin errors++; $display("FAIL hsync_rise: got %b expected 1", hsync0); end
    wait_cyc(5824);
    checks++; if (hsync0 !== 1'b1) begin errors++; $display("FAIL hsync_before_line1: got %b expected 1", hsync0); end
    wait_cyc(5825);
    checks++; if (hsync0 !== 1'b0) begin errors++; $display("FAIL hsync_period: got %b expected 0", hsync0); end
  endtask

  task automatic test_vsync_timing();
    wait_cyc(1 + D * HT * (VA + VF) - 1);
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL vsync_before: got %b expected 1", vsync); end
    wait_cyc(1 + D * HT * (VA + VF));
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL vsync_fall: got %b expected 0", vsync); end
    wait_cyc(D * HT * (VA + VF + VS));
    checks++; if (vsync !== 1'b0) begin errors++; $display("FAIL vsync_last_low: got %b expected 0", vsync); end
    wait_cyc(1 + D * HT * (VA + VF + VS));
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL vsync_rise: got %b expected 1", vsync); end
  endtask

  task automatic test_frame_start(int unsigned fr);
    wait_cyc(fr * FC - 1);
    checks++; if (fs !== 1'b0) begin errors++; $display("FAIL frame_start_pre%0d: got %b expected 0", fr, fs); end
    wait_cyc(fr * FC);
    checks++; if (fs !== 1'b1) begin errors++; $display("FAIL frame_start_pulse%0d: got %b expected 1", fr, fs); end
    wait_cyc(fr * FC + 1);
    checks++; if (fs !== 1'b0) begin errors++; $display("FAIL frame_start_post%0d: got %b expected 0", fr, fs); end
  endtask

  task automatic test_box_edges();
    int unsigned xs [26] = '{8, 3, 4, 13, 14, 17, 18, 27, 28, 3, 4, 5, 6, 8, 22, 36, 50, 56, 63, 64, 79, 8, 8, 8, 0, 79};
    int unsigned ys [26] = '{9, 10, 10, 10, 10, 10, 10, 10, 10, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 15, 20, 21, 22, 40, 46};
    logic [12:0] cs [26] = '{13'h1123, 13'h1123, 0, 0, 13'h1123, 13'h1123, 0, 0, 13'h1123, 13'h1123, 0, 0, 0,
                              13'h10FF, 13'h1F0F, 13'h1FF0, 13'h108C, 13'h1123, 13'h1123, 13'h1000, 13'h1000,
                              0, 0, 13'h1123, 13'h1000, 13'h1000};
    logic [11:0] e;
    for (int k = 0; k < 26; k++) begin
      wait_px(1, xs[k], ys[k]);
      e = exp_rgb(xs[k], ys[k], shadow_m[1]);
      checks++; if (rgb !== e) begin errors++; $display("FAIL edge_rgb(%0d,%0d): got %h expected %h", xs[k], ys[k], rgb, e); end
      if (cs[k][12]) begin
        checks++; if (rgb !== cs[k][11:0]) begin errors++; $display("FAIL edge_const(%0d,%0d): got %h expected %h", xs[k], ys[k], rgb, cs[k][11:0]); end
      end
      checks++; if (hsync !== exp_hs(xs[k]) || vsync !== exp_vs(ys[k])) begin
        errors++; $display("FAIL edge_sync(%0d,%0d): got %b%b expected %b%b", xs[k], ys[k], hsync, vsync, exp_hs(xs[k]), exp_vs(ys[k]));
      end
    end
  endtask

  task automatic test_no_tear();
    int unsigned x;
    logic [11:0] e;
    for (int unsigned y = 0; y < VT; y++) begin
      x = (y == 16) ? 8 : $urandom_range(0, HT - 1);
      wait_px(2, x, y);
      e = exp_rgb(x, y, shadow_m[2]);
      checks++; if (rgb !== e) begin errors++; $display("FAIL tear_rgb(%0d,%0d): got %h expected %h", x, y, rgb, e); end
      if (y == 16) begin
        checks++; if (rgb !== 12'h0FF) begin errors++; $display("FAIL tear_const: got %h expected 0FF", rgb); end
      end
      checks++; if (hsync !== exp_hs(x) || vsync !== exp_vs(y)) begin
        errors++; $display("FAIL tear_sync(%0d,%0d): got %b%b expected %b%b", x, y, hsync, vsync, exp_hs(x), exp_vs(y));
      end
      if (y == 12) fullColor = 48'hFF0_00F_0F0_F00;
    end
  endtask

  task automatic test_next_frame();
    wait_px(3, 8, 15);
    checks++; if (rgb !== 12'hF00) begin errors++; $display("FAIL next_slot0: got %h expected F00", rgb); end
    wait_px(3, 50, 15);
    checks++; if (rgb !== 12'hFF0) begin errors++; $display("FAIL next_slot3: got %h expected FF0", rgb); end
    fullColor = {$urandom, $urandom};
  endtask

  task automatic test_random_sweep();
    int unsigned x [2];
    logic [11:0] e;
    for (int unsigned y = 0; y < VT; y++) begin
      x[0] = $urandom_range(0, HT / 2 - 1);
      x[1] = $urandom_range(HT / 2, HT - 1);
      for (int j = 0; j < 2; j++) begin
        wait_px(4, x[j], y);
        e = exp_rgb(x[j], y, shadow_m[4]);
        checks++; if (rgb !== e) begin errors++; $display("FAIL rand_rgb(%0d,%0d): got %h expected %h", x[j], y, rgb, e); end
        checks++; if (hsync !== exp_hs(x[j])) begin errors++; $display("FAIL rand_hsync(%0d,%0d): got %b expected %b", x[j], y, hsync, exp_hs(x[j])); end
        checks++; if (vsync !== exp_vs(y)) begin errors++; $display("FAIL rand_vsync(%0d,%0d): got %b expected %b", x[j], y, vsync, exp_vs(y)); end
      end
      if (y == 40) fullColor = 48'hFFF_FFF_FFF_FFF;
    end
  endtask

  task automatic test_blanking();
    wait_px(5, 8, 15);
    checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL blank_ref_box: got %h expected FFF", rgb); end
    wait_px(5, HA, 15);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blank_right: got %h expected 000", rgb); end
    wait_px(5, 0, VA);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blank_bottom: got %h expected 000", rgb); end
    wait_px(5, HT - 1, VT - 1);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL blank_corner: got %h expected 000", rgb); end
  endtask

  task automatic test_midframe_reset();
    wait_px(6, 30, 12);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rgb !== 12'h000 || hsync !== 1'b1 || vsync !== 1'b1 || fs !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got %h %b%b%b expected 000 110", rgb, hsync, vsync, fs);
    end
    reset = 1'b0;
    wait_px(0, 0, 0);
    checks++; if (rgb !== BGC) begin errors++; $display("FAIL midreset_origin: got %h expected %h", rgb, BGC); end
    wait_px(0, 8, 15);
    checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL midreset_shadow: got %h expected 000", rgb); end
    wait_cyc(2625);
    checks++; if (hsync0 !== 1'b0) begin errors++; $display("FAIL midreset_hsync0: got %b expected 0", hsync0); end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    shadow_m[0] = '0;
    test_reset();
    test_first_frame_shadow();
    test_hsync_timing();
    test_vsync_timing();
    test_frame_start(1);
    test_box_edges();
    test_frame_start(2);
    test_no_tear();
    test_frame_start(3);
    test_next_frame();
    test_frame_start(4);
    test_random_sweep();
    test_frame_start(5);
    test_blanking();
    test_midframe_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
